// File: rtl/kmeans_centroid_sink.sv
// kmeans_centroid_sink: captures a k-means centroid burst, checks its length,
// optionally sorts it ascending (odd-even transposition), and streams it out
// over a valid/ready interface with index and last markers.
module kmeans_centroid_sink #(
  parameter int unsigned CLUSTER_SIZE = 4,
  parameter int unsigned DATA_W       = 16,
  parameter bit          SORT_EN      = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_W-1:0]                 m_data,
  output logic [$clog2(CLUSTER_SIZE)-1:0]   m_index,
  output logic                              m_last,
  output logic                              frame_err,
  output logic                              busy
);

  localparam int unsigned CNT_W = $clog2(CLUSTER_SIZE) + 1;
  localparam int unsigned IDX_W = $clog2(CLUSTER_SIZE);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLUSTER_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLUSTER_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CLUSTER_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SORT    = 3'd2,
    S_SEND    = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [CLUSTER_SIZE];
  logic [DATA_W-1:0]   mem_d [CLUSTER_SIZE];
  logic [DATA_W-1:0]   sorted_c [CLUSTER_SIZE];
  logic                block_q, block_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [IDX_W-1:0]    m_index_q, m_index_d;
  logic                m_last_q, m_last_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic [IDX_W-1:0]    nxt_idx_c;

  // One transposition pass; parity of the pass counter selects even/odd pairs
  always_comb begin
    sorted_c = mem_q;
    for (int i = 0; i < int'(CLUSTER_SIZE) - 1; i++) begin
      if (((i % 2) == int'(cnt_q[0])) && (mem_q[i] > mem_q[i+1])) begin
        sorted_c[i]   = mem_q[i+1];
        sorted_c[i+1] = mem_q[i];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_d       = mem_q;
    block_d     = block_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_index_d   = m_index_q;
    m_last_d    = m_last_q;
    frame_err_d = 1'b0;
    nxt_idx_c   = IDX_W'(cnt_q + CNT_W'(1));

    // An ignored overlapping burst stays ignored until in_valid drops
    if (!in_valid) begin
      block_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && !block_q) begin
          mem_d[0] = in_data;
          cnt_d    = CNT_W'(1);
          state_d  = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (in_valid) begin
          if (cnt_q == CNT_FULL) begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_DRAIN;
          end else begin
            mem_d[IDX_W'(cnt_q)] = in_data;
            cnt_d                = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (SORT_EN) begin
            state_d = S_SORT;
          end else begin
            state_d   = S_SEND;
            m_valid_d = 1'b1;
            m_data_d  = mem_q[0];
            m_index_d = '0;
            m_last_d  = 1'b0;
          end
        end else begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end

      S_SORT: begin
        if (in_valid && !block_q) begin
          frame_err_d = 1'b1;
          block_d     = 1'b1;
        end
        mem_d = sorted_c;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          state_d   = S_SEND;
          m_valid_d = 1'b1;
          m_data_d  = sorted_c[0];
          m_index_d = '0;
          m_last_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SEND: begin
        if (in_valid && !block_q) begin
          frame_err_d = 1'b1;
          block_d     = 1'b1;
        end
        if (m_valid_q && m_ready) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            m_data_d  = mem_q[nxt_idx_c];
            m_index_d = nxt_idx_c;
            m_last_d  = (nxt_idx_c == IDX_LAST);
          end
        end
      end

      S_DRAIN: begin
        if (!in_valid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, buffer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      block_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_index_q   <= '0;
      m_last_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < int'(CLUSTER_SIZE); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_index_q   <= m_index_d;
      m_last_q    <= m_last_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_index   = m_index_q;
  assign m_last    = m_last_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
